// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared types, defaults and width helper for product_accumulator
package product_acc_pkg;

    // FSM states: ACC collects a group, HOLD presents a finished sum
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    // Defaults match the upstream multiplier's result width and a 4-tap group
    localparam int PA_WIDTH_IN = 16;
    localparam int PA_LEN      = 4;

    // Accumulator width that can hold len full-scale products without wrapping
    function automatic int acc_width(input int width_in, input int len);
        return width_in + $clog2(len);
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums groups of up to LEN products and hands each sum off on a valid/ready port
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter  int WIDTH_IN  = PA_WIDTH_IN,
    parameter  int LEN       = PA_LEN,
    localparam int WIDTH_ACC = acc_width(WIDTH_IN, LEN),
    localparam int CNT_W     = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  in_res,
    input  logic                 in_vld,
    input  logic                 in_last,
    output logic                 in_rdy,
    output logic [WIDTH_ACC-1:0] out_sum,
    output logic [CNT_W-1:0]     out_cnt,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    // Beat index that fills a group to LEN products
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    acc_state_t           state, state_nxt;
    logic [WIDTH_ACC-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [WIDTH_ACC-1:0] sum_nxt;
    logic [CNT_W-1:0]     ocnt_nxt;

    logic                 beat;
    logic                 closes;
    logic                 take_result;
    logic [WIDTH_ACC-1:0] beat_sum;
    logic [CNT_W-1:0]     beat_cnt;

    // Handshake and adder terms shared by both states; acc/cnt are zero at the
    // start of every group, so a beat taken in HOLD uses the same datapath as ACC
    always_comb begin
        in_rdy      = (state == ACC) || out_rdy;
        out_vld     = (state == HOLD);
        beat        = in_vld && in_rdy;
        take_result = (state == HOLD) && out_rdy;
        closes      = (cnt == LAST_IDX) || in_last;
        beat_sum    = acc + WIDTH_ACC'(in_res);
        beat_cnt    = cnt + CNT_ONE;
    end

    // Next-state logic: close a group into the output register or keep summing
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sum_nxt   = out_sum;
        ocnt_nxt  = out_cnt;
        if (beat) begin
            if (closes) begin
                sum_nxt   = beat_sum;
                ocnt_nxt  = beat_cnt;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = HOLD;
            end else begin
                acc_nxt   = beat_sum;
                cnt_nxt   = beat_cnt;
                state_nxt = ACC;
            end
        end else if (take_result) begin
            state_nxt = ACC;
        end
    end

    // State, accumulator and output registers; reset drops any partial or pending sum
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            out_sum <= sum_nxt;
            out_cnt <= ocnt_nxt;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_res;
    logic        in_vld;
    logic        in_last;
    logic        in_rdy;
    logic [17:0] out_sum;
    logic [2:0]  out_cnt;
    logic        out_vld;
    logic        out_rdy;

    logic [15:0] d8;
    logic        v8;
    logic        l8;
    logic        rdy8;
    logic [18:0] sum8;
    logic [3:0]  cnt8;
    logic        ovld8;
    logic        r8;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int sum;
        int cnt;
    } res_t;

    res_t exp_q[$];
    int   g_sum = 0;
    int   g_cnt = 0;

    always #5 clk = ~clk;

    product_accumulator #(.WIDTH_IN(16), .LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_res  (in_res),
        .in_vld  (in_vld),
        .in_last (in_last),
        .in_rdy  (in_rdy),
        .out_sum (out_sum),
        .out_cnt (out_cnt),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    product_accumulator #(.WIDTH_IN(16), .LEN(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .in_res  (d8),
        .in_vld  (v8),
        .in_last (l8),
        .in_rdy  (rdy8),
        .out_sum (sum8),
        .out_cnt (cnt8),
        .out_vld (ovld8),
        .out_rdy (r8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the LEN=4 instance, checked against the group model
    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
        logic exp_rdy;
        res_t e;
        in_vld  = v;
        in_res  = d;
        in_last = l;
        out_rdy = r;
        @(negedge clk);
        exp_rdy = (exp_q.size() == 0) || r;
        chk("in_rdy", in_rdy, exp_rdy);
        chk("out_vld", out_vld, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("out_sum", out_sum, e.sum);
            chk("out_cnt", out_cnt, e.cnt);
            if (r) void'(exp_q.pop_front());
        end
        if (v && exp_rdy) begin
            g_sum += d;
            g_cnt++;
            if (l || g_cnt == 4) begin
                e.sum = g_sum;
                e.cnt = g_cnt;
                exp_q.push_back(e);
                g_sum = 0;
                g_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        in_last = 1'b0;
        in_res  = '0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        g_sum = 0;
        g_cnt = 0;
    endtask

    initial begin
        logic [15:0] rv;
        logic        vv;
        logic        lv;
        logic        ov;
        v8 = 1'b0; d8 = '0; l8 = 1'b0; r8 = 1'b1;
        out_rdy = 1'b1;
        do_reset();
        do_reset();

        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_in_rdy", in_rdy, 1);

        // Full group of four
        step(1, 3, 0, 1);
        step(1, 5, 0, 1);
        step(1, 7, 0, 1);
        step(1, 11, 0, 1);
        chk("g4_vld", out_vld, 1);
        chk("g4_sum", out_sum, 26);
        chk("g4_cnt", out_cnt, 4);
        step(0, 0, 0, 1);
        chk("g4_vld_clear", out_vld, 0);

        // Early close, then a fresh group
        step(1, 100, 0, 1);
        step(1, 200, 1, 1);
        chk("early_sum", out_sum, 300);
        chk("early_cnt", out_cnt, 2);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
        chk("ones_sum", out_sum, 4);
        step(0, 0, 0, 1);

        // Full-scale group does not wrap
        for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 0, 1);
        chk("max_sum", out_sum, 32'h3FFFC);
        chk("max_cnt", out_cnt, 4);
        step(0, 0, 0, 1);

        // Backpressure with upstream holding beat 9
        for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 9, 0, 0);
            chk("bp_in_rdy", in_rdy, 0);
            chk("bp_sum", out_sum, 10);
        end
        step(1, 9, 0, 1);
        chk("bp_vld_after", out_vld, 0);
        step(1, 1, 1, 1);
        chk("bp_next_sum", out_sum, 10);
        chk("bp_next_cnt", out_cnt, 2);
        step(0, 0, 0, 1);

        // Back-to-back single-beat groups
        step(1, 7, 1, 1);
        chk("b2b_7", out_sum, 7);
        step(1, 8, 1, 1);
        chk("b2b_8", out_sum, 8);
        step(1, 9, 1, 1);
        chk("b2b_9", out_sum, 9);
        chk("b2b_cnt", out_cnt, 1);
        step(0, 0, 0, 1);

        // Bubbles and ignored in_last on idle cycles
        step(1, 2, 0, 1);
        step(0, 0, 1, 1);
        step(1, 3, 0, 1);
        step(0, 0, 0, 1);
        step(1, 4, 1, 1);
        chk("bubble_sum", out_sum, 9);
        chk("bubble_cnt", out_cnt, 3);
        step(0, 0, 0, 1);

        // Reset mid-group discards the partial sum
        step(1, 50, 0, 1);
        step(1, 60, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
        chk("rst_mid_sum", out_sum, 4);
        step(0, 0, 0, 1);

        // Reset while holding a result
        step(1, 5, 1, 0);
        step(0, 0, 0, 0);
        do_reset();
        chk("rst_hold_vld", out_vld, 0);
        step(0, 0, 0, 1);

        // Randomised traffic against the group model
        for (int i = 0; i < 400; i++) begin
            vv = ($urandom_range(0, 3) != 0);
            lv = ($urandom_range(0, 4) == 0);
            ov = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            step(vv, rv, lv, ov);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        chk("drain_empty", exp_q.size(), 0);

        // LEN=8 instance: full-scale group
        for (int i = 0; i < 8; i++) begin
            v8 = 1'b1;
            d8 = 16'hFFFF;
            @(negedge clk);
            chk("l8_in_rdy", rdy8, 1);
            @(posedge clk);
            #1;
        end
        v8 = 1'b0;
        chk("l8_vld", ovld8, 1);
        chk("l8_sum", sum8, 32'h7FFF8);
        chk("l8_cnt", cnt8, 8);
        @(posedge clk);
        #1;
        chk("l8_vld_clear", ovld8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
